// File: rtl/operand_slot_selector_pkg.sv
// Shared definitions for the operand slot selector and its storage/search peers:
// FSM state encoding and the slot-index / slot-count width rules.
package operand_slot_selector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    FETCH = 2'd2,
    SHOW  = 2'd3
  } sel_state_t;

  // Width of a slot index for a store of n slots.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  // Width of a count/ordinal able to hold 0..n.
  function automatic int unsigned count_bits(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n + 1));
  endfunction

endpackage

// File: rtl/operand_slot_selector_mask_popcount_upto.sv
// mask_popcount_upto: number of set mask bits at positions 0..idx inclusive.
// Gives the 1-based ordinal of slot idx among the matching slots.
module mask_popcount_upto
  import operand_slot_selector_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned IDX_BITS   = idx_bits(WIDTH),
  parameter int unsigned COUNT_BITS = count_bits(WIDTH)
) (
  input  logic [WIDTH-1:0]      mask,
  input  logic [IDX_BITS-1:0]   idx,
  output logic [COUNT_BITS-1:0] count_c
);

  // Count set bits up to and including idx.
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((i <= 32'(idx)) && mask[i]) begin
        count_c = count_c + COUNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/operand_slot_selector.sv
// operand_slot_selector: walks the slots flagged by a match mask one at a time,
// fetches each from matrix storage over rd_req/rd_ack, and lets the user step
// (next), pick (confirm) or abort (cancel). The confirmed index is held on sel_idx.
// Optional build macro SEL_TIMEOUT_EN: abort a SHOW left idle for TIMEOUT_CYCLES.
module operand_slot_selector
  import operand_slot_selector_pkg::*;
#(
  parameter int unsigned MAX_STORE      = 2,
  parameter int unsigned IDX_BITS       = idx_bits(MAX_STORE),
  parameter int unsigned COUNT_BITS     = count_bits(MAX_STORE),
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MAX_STORE-1:0]  match_mask,
  input  logic                  next_pulse,
  input  logic                  confirm_pulse,
  input  logic                  cancel_pulse,
  output logic                  rd_req,
  output logic [IDX_BITS-1:0]   rd_slot,
  input  logic                  rd_ack,
  output logic                  busy,
  output logic                  show_valid,
  output logic [COUNT_BITS-1:0] sel_ordinal,
  output logic                  done,
  output logic [IDX_BITS-1:0]   sel_idx,
  output logic                  none_found,
  output logic                  aborted
);

  sel_state_t             state;
  logic [MAX_STORE-1:0]   mask_q;
  logic [IDX_BITS-1:0]    ptr;
  logic [IDX_BITS-1:0]    ptr_inc_c;
  logic [COUNT_BITS-1:0]  ordinal_c;
  logic                   tmr_hit_c;

  // Pointer advance with wrap from the last slot back to slot 0.
  always_comb begin
    ptr_inc_c = ptr + IDX_BITS'(1);
    if (ptr == IDX_BITS'(MAX_STORE - 1)) begin
      ptr_inc_c = '0;
    end
  end

  mask_popcount_upto #(
    .WIDTH      (MAX_STORE),
    .IDX_BITS   (IDX_BITS),
    .COUNT_BITS (COUNT_BITS)
  ) u_ordinal (
    .mask    (mask_q),
    .idx     (ptr),
    .count_c (ordinal_c)
  );

`ifdef SEL_TIMEOUT_EN
  localparam int unsigned TMR_BITS = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TMR_BITS-1:0] tmr;

  // Idle counter for SHOW; restarts on SHOW entry and on any user event.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state != SHOW) || next_pulse || confirm_pulse || cancel_pulse) begin
      tmr <= '0;
    end else if (!tmr_hit_c) begin
      tmr <= tmr + TMR_BITS'(1);
    end
  end

  assign tmr_hit_c = (state == SHOW) && (tmr == TMR_BITS'(TIMEOUT_CYCLES - 1));
`else
  // No counter: SHOW waits indefinitely. The term keeps the parameter in the
  // interface so both builds instantiate identically; it is constant 0.
  assign tmr_hit_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Session FSM with registered handshake, status and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      ptr         <= '0;
      rd_req      <= 1'b0;
      rd_slot     <= '0;
      busy        <= 1'b0;
      show_valid  <= 1'b0;
      sel_ordinal <= '0;
      done        <= 1'b0;
      sel_idx     <= '0;
      none_found  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done       <= 1'b0;
      none_found <= 1'b0;
      aborted    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (match_mask == '0) begin
              none_found <= 1'b1;
            end else begin
              mask_q <= match_mask;
              ptr    <= '0;
              busy   <= 1'b1;
              state  <= SEEK;
            end
          end
        end
        SEEK: begin
          if (cancel_pulse) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (mask_q[ptr]) begin
            rd_slot <= ptr;
            rd_req  <= 1'b1;
            state   <= FETCH;
          end else begin
            ptr <= ptr_inc_c;
          end
        end
        FETCH: begin
          if (cancel_pulse) begin
            aborted <= 1'b1;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (rd_ack) begin
            rd_req      <= 1'b0;
            show_valid  <= 1'b1;
            sel_ordinal <= ordinal_c;
            state       <= SHOW;
          end
        end
        SHOW: begin
          if (cancel_pulse || tmr_hit_c) begin
            aborted    <= 1'b1;
            show_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (confirm_pulse) begin
            sel_idx    <= ptr;
            done       <= 1'b1;
            show_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (next_pulse) begin
            ptr        <= ptr_inc_c;
            show_valid <= 1'b0;
            state      <= SEEK;
          end
        end
        default: begin
          rd_req     <= 1'b0;
          show_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_slot_selector.sv
// Bench for operand_slot_selector with MAX_STORE=4: directed scenarios then
// randomized sessions checked against a match-list model of the selection walk.
module tb_operand_slot_selector;

  localparam int M  = 4;
  localparam int IB = 2;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [M-1:0]  match_mask = '0;
  logic          next_pulse = 1'b0;
  logic          confirm_pulse = 1'b0;
  logic          cancel_pulse = 1'b0;
  logic          rd_req;
  logic [IB-1:0] rd_slot;
  logic          rd_ack = 1'b0;
  logic          busy;
  logic          show_valid;
  logic [CB-1:0] sel_ordinal;
  logic          done;
  logic [IB-1:0] sel_idx;
  logic          none_found;
  logic          aborted;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sel = 0;

  operand_slot_selector #(
    .MAX_STORE      (M),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .match_mask    (match_mask),
    .next_pulse    (next_pulse),
    .confirm_pulse (confirm_pulse),
    .cancel_pulse  (cancel_pulse),
    .rd_req        (rd_req),
    .rd_slot       (rd_slot),
    .rd_ack        (rd_ack),
    .busy          (busy),
    .show_valid    (show_valid),
    .sel_ordinal   (sel_ordinal),
    .done          (done),
    .sel_idx       (sel_idx),
    .none_found    (none_found),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from the sampling edge of start/next until the wanted slot is read:
  // one slot examined per cycle, starting just after 'from' (from=-1 at start).
  function automatic int seek_lat(input int from, input int to);
    return ((to - from - 1 + 2 * M) % M) + 1;
  endfunction

  task automatic wait_fetch(input int lat, input int slot, input string tag);
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 4 * M) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_slot"}, 32'(rd_slot), 32'(slot));
  endtask

  task automatic ack_show(input int dly, input int ord, input string tag);
    repeat (dly) tick();
    check({tag, "_req_held"}, 32'(rd_req), 32'd1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check({tag, "_show"}, 32'(show_valid), 32'd1);
    check({tag, "_req_drop"}, 32'(rd_req), 32'd0);
    check({tag, "_ord"}, 32'(sel_ordinal), 32'(ord));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic do_start(input logic [M-1:0] m);
    match_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_next();
    next_pulse = 1'b1;
    tick();
    next_pulse = 1'b0;
    check("next_show_low", 32'(show_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(rd_req), 32'd0);
    check({tag, "_slot"}, 32'(rd_slot), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_show"}, 32'(show_valid), 32'd0);
    check({tag, "_ord"}, 32'(sel_ordinal), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_selidx"}, 32'(sel_idx), 32'd0);
    check({tag, "_none"}, 32'(none_found), 32'd0);
    check({tag, "_abort"}, 32'(aborted), 32'd0);
  endtask

  initial begin
    logic [M-1:0] m;
    int q[$];
    int pos;
    int prev;
    int nn;
    int n;

    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Empty mask: none_found pulse, nothing else moves
    do_start(4'b0000);
    check("empty_none", 32'(none_found), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_req", 32'(rd_req), 32'd0);
    tick();
    check("empty_none_clr", 32'(none_found), 32'd0);
    check("empty_req2", 32'(rd_req), 32'd0);

    // Mask 1010: slots 1 then 3, wrapping back to 1
    do_start(4'b1010);
    wait_fetch(2, 1, "m1010_a");
    ack_show(2, 1, "m1010_a");
    do_next();
    wait_fetch(2, 3, "m1010_b");
    ack_show(0, 2, "m1010_b");
    do_next();
    wait_fetch(2, 1, "m1010_c");
    ack_show(1, 1, "m1010_c");
    cancel_pulse = 1'b1;
    tick();
    cancel_pulse = 1'b0;
    check("m1010_abort", 32'(aborted), 32'd1);
    check("m1010_busy", 32'(busy), 32'd0);
    tick();
    check("m1010_abort_clr", 32'(aborted), 32'd0);

    // Single match 0100: refetch on next, then confirm
    do_start(4'b0100);
    wait_fetch(3, 2, "m0100_a");
    ack_show(0, 1, "m0100_a");
    do_next();
    wait_fetch(4, 2, "m0100_b");
    ack_show(1, 1, "m0100_b");
    confirm_pulse = 1'b1;
    tick();
    confirm_pulse = 1'b0;
    exp_sel = 2;
    check("m0100_done", 32'(done), 32'd1);
    check("m0100_selidx", 32'(sel_idx), 32'(exp_sel));
    check("m0100_busy", 32'(busy), 32'd0);
    tick();
    check("m0100_done_clr", 32'(done), 32'd0);
    // Cancel in SEEK leaves sel_idx alone
    do_start(4'b1111);
    cancel_pulse = 1'b1;
    tick();
    cancel_pulse = 1'b0;
    check("seek_cancel_abort", 32'(aborted), 32'd1);
    check("seek_cancel_req", 32'(rd_req), 32'd0);
    check("seek_cancel_selidx", 32'(sel_idx), 32'(exp_sel));

    // All three events at once in SHOW: cancel wins
    do_start(4'b1001);
    wait_fetch(1, 0, "m1001");
    ack_show(0, 1, "m1001");
    next_pulse = 1'b1;
    confirm_pulse = 1'b1;
    cancel_pulse = 1'b1;
    tick();
    next_pulse = 1'b0;
    confirm_pulse = 1'b0;
    cancel_pulse = 1'b0;
    check("prio_abort", 32'(aborted), 32'd1);
    check("prio_done", 32'(done), 32'd0);
    check("prio_selidx", 32'(sel_idx), 32'(exp_sel));
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_show", 32'(show_valid), 32'd0);

    // Reset mid-handshake, then late ack/next are ignored
    do_start(4'b1000);
    wait_fetch(4, 3, "rst_fetch");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");
    exp_sel = 0;
    rd_ack = 1'b1;
    next_pulse = 1'b1;
    tick();
    rd_ack = 1'b0;
    next_pulse = 1'b0;
    check_all_zero("post_rst");

`ifdef SEL_TIMEOUT_EN
    // Idle SHOW aborts 8 cycles after show_valid rises; a next restarts it
    do_start(4'b0010);
    wait_fetch(2, 1, "tmo_a");
    ack_show(0, 1, "tmo_a");
    n = 0;
    while (aborted !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tmo_a_cycles", 32'(n), 32'd8);
    do_start(4'b0010);
    wait_fetch(2, 1, "tmo_b");
    ack_show(0, 1, "tmo_b");
    repeat (4) tick();
    do_next();
    wait_fetch(4, 1, "tmo_c");
    ack_show(0, 1, "tmo_c");
    n = 0;
    while (aborted !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tmo_c_cycles", 32'(n), 32'd8);
    tick();
`endif

    // Randomized sessions against the match-list model
    for (int s = 0; s < 40; s++) begin
      m = M'($urandom_range(1, (1 << M) - 1));
      q.delete();
      for (int i = 0; i < M; i++) begin
        if (m[i]) q.push_back(i);
      end
      do_start(m);
      match_mask = M'($urandom);
      check("r_busy", 32'(busy), 32'd1);
      pos = 0;
      prev = -1;
      if ($urandom_range(0, 7) == 0) begin
        wait_fetch(seek_lat(prev, q[0]), q[0], "r_fcancel");
        cancel_pulse = 1'b1;
        tick();
        cancel_pulse = 1'b0;
        check("r_fcancel_abort", 32'(aborted), 32'd1);
        check("r_fcancel_req", 32'(rd_req), 32'd0);
        check("r_fcancel_selidx", 32'(sel_idx), 32'(exp_sel));
        tick();
        continue;
      end
      nn = int'($urandom_range(0, 5));
      for (int k = 0; k <= nn; k++) begin
        wait_fetch(seek_lat(prev, q[pos]), q[pos], "r_fetch");
        ack_show(int'($urandom_range(0, 3)), pos + 1, "r_show");
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          rd_ack = 1'b1;
          tick();
          start = 1'b0;
          rd_ack = 1'b0;
          check("r_ign_show", 32'(show_valid), 32'd1);
          check("r_ign_none", 32'(none_found), 32'd0);
          check("r_ign_req", 32'(rd_req), 32'd0);
          check("r_ign_ord", 32'(sel_ordinal), 32'(pos + 1));
        end
        if (k < nn) begin
          do_next();
          prev = q[pos];
          pos = (pos + 1) % q.size();
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        confirm_pulse = 1'b1;
        tick();
        confirm_pulse = 1'b0;
        exp_sel = q[pos];
        check("r_done", 32'(done), 32'd1);
        check("r_abort_low", 32'(aborted), 32'd0);
      end else begin
        cancel_pulse = 1'b1;
        tick();
        cancel_pulse = 1'b0;
        check("r_abort", 32'(aborted), 32'd1);
        check("r_done_low", 32'(done), 32'd0);
      end
      check("r_selidx", 32'(sel_idx), 32'(exp_sel));
      check("r_idle", 32'(busy), 32'd0);
      tick();
      check("r_pulse_clr", 32'({done, aborted}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_slot_selector.md
Name: operand_slot_selector

Overview:
- Sequential controller between search_by_dimensions and matrix_storage.
- On start, latches the match mask and walks the matching slots one at a time.
- Each candidate is fetched from storage over a req/ack handshake and presented; the user steps with next, and picks one with confirm or aborts with cancel.
- Output is the confirmed slot index, used as an operand by the upstream FSM for compute and display.

Parameters:
- MAX_STORE, 2, number of storage slots; must match matrix_storage.
- IDX_BITS, (MAX_STORE<=1)?1:$clog2(MAX_STORE), width of a slot index.
- COUNT_BITS, (MAX_STORE<=1)?1:$clog2(MAX_STORE+1), width of counts and ordinals.
- TIMEOUT_CYCLES, 500000000, idle cycles allowed in SHOW; used only with SEL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a selection session; ignored unless in IDLE.
- match_mask  in  MAX_STORE  slot match mask; sampled only on an accepted start.
- next_pulse  in  1  one-cycle pulse: advance to the next match.
- confirm_pulse  in  1  one-cycle pulse: accept the shown slot.
- cancel_pulse  in  1  one-cycle pulse: abort the session.
- rd_req  out  1  storage read request; held high until rd_ack.
- rd_slot  out  IDX_BITS  slot being read; stable while rd_req is high.
- rd_ack  in  1  storage read done; data is valid in this cycle.
- busy  out  1  high in any state other than IDLE.
- show_valid  out  1  high in SHOW; the storage data for rd_slot is presentable.
- sel_ordinal  out  COUNT_BITS  1-based position of the shown slot among the matches.
- done  out  1  one-cycle pulse on confirm.
- sel_idx  out  IDX_BITS  confirmed slot; updated only when done fires, held otherwise.
- none_found  out  1  one-cycle pulse when start arrives with match_mask==0.
- aborted  out  1  one-cycle pulse on cancel (or on timeout).

Behaviour:
- Reset: state=IDLE; the pointer ptr, the latched mask, rd_slot, sel_idx and sel_ordinal are all 0; every 1-bit output is 0. Reset wins over all inputs, including mid-handshake.
- States: IDLE, SEEK, FETCH, SHOW. done, none_found and aborted are registered pulses, high exactly one cycle.
- IDLE + start:
  - match_mask==0: none_found=1 next cycle; stay in IDLE.
  - otherwise: latch the mask, ptr=0, go to SEEK.
- SEEK: examine one slot per cycle.
  - mask[ptr]==1: rd_slot=ptr, go to FETCH.
  - mask[ptr]==0: ptr increments, wrapping from MAX_STORE-1 to 0.
  - The latched mask is non-zero, so SEEK ends within MAX_STORE cycles.
  - Latency from start to rd_req high = 1 + (index of the first set bit) + 1 cycles.
- FETCH: rd_req=1. On rd_ack: rd_req drops in the next cycle and the state goes to SHOW.
  - sel_ordinal = popcount(mask[ptr:0]), registered on this transition.
  - An rd_ack seen outside FETCH is ignored.
- SHOW: show_valid=1. One event per cycle, priority cancel > confirm > next.
  - cancel: aborted pulse, go to IDLE.
  - confirm: sel_idx=ptr, done pulse, go to IDLE.
  - next: ptr=ptr+1 with wrap, go to SEEK.
  - A single match cycles back to itself: SEEK→FETCH refetches the same slot and sel_ordinal stays 1.
- Input handling:
  - cancel in SEEK or FETCH aborts immediately; rd_req drops in the next cycle.
  - next and confirm are ignored outside SHOW.
  - start is ignored while busy.
- The mask is frozen for the whole session; changes on match_mask mid-session have no effect.

Optional Feature:
- SEL_TIMEOUT_EN defined: a counter clears on entry to SHOW and on every next, confirm or cancel. When it reaches TIMEOUT_CYCLES-1 while in SHOW, the block behaves exactly as if cancel had arrived (aborted pulse, go to IDLE).
- Not defined: no counter is built, and SHOW waits indefinitely.

Decomposition:
- Shared package: state encoding constants (IDLE=0, SEEK=1, FETCH=2, SHOW=3) and the IDX_BITS/COUNT_BITS width expressions, reused with search_by_dimensions and matrix_storage.
- One natural sub-module, mask_popcount_upto: combinational count of the set bits of a mask at positions ≤ idx, producing sel_ordinal.
- The FSM, pointer and handshake stay in the top module.

Test Plan:
1. MAX_STORE=4, start with mask=4'b0000 → none_found pulse 1 cycle later; busy stays 0; rd_req never asserts.
2. mask=4'b1010, start, rd_ack 2 cycles after rd_req → first rd_req with rd_slot=1 at start+3. In SHOW, sel_ordinal=1. After next: rd_slot=3, sel_ordinal=2. After next again: wraps to rd_slot=1.
3. mask=4'b0100; start; ack; then confirm → done pulse with sel_idx=2; busy=0 the following cycle; sel_idx holds 2 after later start/cancel sessions until the next done.
4. In SHOW, assert next, confirm and cancel in the same cycle → aborted only; no done; sel_idx unchanged; state IDLE.
5. rst asserted while rd_req=1 in FETCH → next cycle all outputs are 0 and state is IDLE; a late rd_ack and next_pulse have no effect.
6. With SEL_TIMEOUT_EN and TIMEOUT_CYCLES=8: reach SHOW with no input → aborted pulse exactly 8 cycles after show_valid rises. A next at cycle 5 restarts the count.
